// File: rtl/mux_3x1.sv
// mux_3x1: 3-to-1 selector for datapath operand A.
//   select 00 -> in_00 (data memory), 01 -> in_01 (extender), 10 -> in_10 (ALU).
//   select 11 is illegal: it drives zero, or the last legally selected value
//   when MUX_3X1_SEL_HOLD_EN is defined.
// mux_out is combinational; mux_out_q and sel_err are registered copies for
// pipeline/debug consumers. Asynchronous active-low reset on rst_n.
module mux_3x1 #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_00,
  input  logic [DATA_WIDTH-1:0] in_01,
  input  logic [DATA_WIDTH-1:0] in_10,
  input  logic [1:0]            select_3x1,
  output logic [DATA_WIDTH-1:0] mux_out,
  output logic [DATA_WIDTH-1:0] mux_out_q,
  output logic                  sel_err
);

`ifdef MUX_3X1_SEL_HOLD_EN
  logic [DATA_WIDTH-1:0] hold_q;

  // Remember the last legally selected value for replay on the illegal code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (select_3x1 != 2'b11) begin
      hold_q <= mux_out;
    end
  end
`endif

  // Select the operand; an unknown select falls to default and yields X in simulation.
  always_comb begin
    mux_out = '0;
    case (select_3x1)
      2'b00:   mux_out = in_00;
      2'b01:   mux_out = in_01;
      2'b10:   mux_out = in_10;
`ifdef MUX_3X1_SEL_HOLD_EN
      2'b11:   mux_out = hold_q;
`else
      2'b11:   mux_out = '0;
`endif
      default: mux_out = 'x;
    endcase
  end

  // Registered copy of the selection and a one-cycle illegal-select flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_out_q <= '0;
      sel_err   <= 1'b0;
    end else begin
      mux_out_q <= mux_out;
      sel_err   <= (select_3x1 == 2'b11);
    end
  end

endmodule

// File: tb/tb_mux_3x1.sv
// tb_mux_3x1: directed literal scenarios followed by randomized stimulus,
// checked against a behavioural model of mux_3x1 (honours MUX_3X1_SEL_HOLD_EN).
module tb_mux_3x1;
  localparam int unsigned W = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_00, in_01, in_10;
  logic [1:0]   select_3x1;
  logic [W-1:0] mux_out, mux_out_q;
  logic         sel_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [W-1:0] exp_q;
  logic         exp_err;
  logic [W-1:0] hold_m;

  mux_3x1 #(.DATA_WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_00(in_00),
    .in_01(in_01),
    .in_10(in_10),
    .select_3x1(select_3x1),
    .mux_out(mux_out),
    .mux_out_q(mux_out_q),
    .sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MUX_3X1_SEL_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  // Reference selection: table lookup for legal codes, illegal code gives hold or zero
  function automatic logic [W-1:0] ref_mux(input logic [1:0] s, input logic [W-1:0] a0,
                                           input logic [W-1:0] a1, input logic [W-1:0] a2,
                                           input logic [W-1:0] h);
    logic [W-1:0] tbl [3];
    tbl[0] = a0; tbl[1] = a1; tbl[2] = a2;
    if (s == 2'd3) return HOLD ? h : '0;
    return tbl[s];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the registered outputs
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q   <= '0;
      exp_err <= 1'b0;
      hold_m  <= '0;
    end else begin
      exp_q   <= ref_mux(select_3x1, in_00, in_01, in_10, hold_m);
      exp_err <= (select_3x1 == 2'd3);
      if (select_3x1 != 2'd3) hold_m <= ref_mux(select_3x1, in_00, in_01, in_10, hold_m);
    end
  end

  // Per-cycle comparison away from the active edge
  always @(negedge clk) begin
    check("cyc_mux_out", mux_out, ref_mux(select_3x1, in_00, in_01, in_10, hold_m));
    check("cyc_mux_out_q", mux_out_q, exp_q);
    check("cyc_sel_err", {15'd0, sel_err}, {15'd0, exp_err});
  end

  initial begin
    // Reset state and legal selects with no clock edge
    rst_n = 1'b0;
    in_00 = 16'h0000; in_01 = 16'h0071; in_10 = 16'hFF82;
    select_3x1 = 2'b00;
    #1;
    check("reset_q", mux_out_q, 16'h0000);
    check("reset_err", {15'd0, sel_err}, 16'h0000);
    check("s1_sel00", mux_out, 16'h0000);
    select_3x1 = 2'b01; #1;
    check("s1_sel01", mux_out, 16'h0071);
    select_3x1 = 2'b10; #1;
    check("s1_sel10", mux_out, 16'hFF82);
    // Unselected input change
    in_01 = 16'h0001; #1;
    check("s2_unselected", mux_out, 16'hFF82);

    @(negedge clk);
    rst_n = 1'b1;
    // Selected input change
    select_3x1 = 2'b00; in_00 = 16'hFC64; #1;
    check("s3_selected", mux_out, 16'hFC64);
    in_01 = 16'h0071;

    // Illegal select
    select_3x1 = 2'b01;
    @(posedge clk); #1;
    select_3x1 = 2'b11; #1;
    check("s4_illegal_out", mux_out, HOLD ? 16'h0071 : 16'h0000);
    @(posedge clk); #1;
    check("s4_err_set", {15'd0, sel_err}, 16'h0001);
    select_3x1 = 2'b00;
    @(posedge clk); #1;
    check("s4_err_clr", {15'd0, sel_err}, 16'h0000);

    // Register latency
    select_3x1 = 2'b10; in_10 = 16'h0102; #1;
    check("s5_before_edge", mux_out_q, 16'hFC64);
    @(posedge clk); #1;
    check("s5_after_edge", mux_out_q, 16'h0102);

    // Async reset mid-cycle with flags set
    select_3x1 = 2'b11;
    @(posedge clk); #1;
    check("s6_pre_err", {15'd0, sel_err}, 16'h0001);
    check("s6_pre_q", mux_out_q, HOLD ? 16'h0102 : 16'h0000);
    select_3x1 = 2'b10; #1;
    rst_n = 1'b0; #1;
    check("s6_rst_q", mux_out_q, 16'h0000);
    check("s6_rst_err", {15'd0, sel_err}, 16'h0000);
    check("s6_rst_mux", mux_out, 16'h0102);
    select_3x1 = 2'b11; #1;
    check("s6_rst_hold_cleared", mux_out, 16'h0000);
    select_3x1 = 2'b10;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized phase
    repeat (500) begin
      @(posedge clk); #1;
      in_00 = W'($urandom);
      in_01 = W'($urandom);
      in_10 = W'($urandom);
      select_3x1 = 2'($urandom_range(0, 3));
      #1;
      check("rnd_mux_now", mux_out, ref_mux(select_3x1, in_00, in_01, in_10, hold_m));
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0; #1;
        check("rnd_rst_q", mux_out_q, 16'h0000);
        check("rnd_rst_err", {15'd0, sel_err}, 16'h0000);
        rst_n = 1'b1;
      end
    end

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
